// File: rtl/uart_tx_feeder.sv
// Byte FIFO with a drain FSM that launches queued bytes into uart_tx in order.
// Detects dropped pushes and a uart_tx that never reports tx_done.
`timescale 1ns / 1ps

module uart_tx_feeder #(
   parameter int unsigned DEPTH        = 16,
   parameter int unsigned ADDR_W       = 4,
   parameter int unsigned TIMEOUT_CLKS = 10000
) (
   input  logic              CLK_50,
   input  logic              RST,
   input  logic              wr_en,
   input  logic [7:0]        wr_data,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W:0]   count,
   output logic              overflow,
   output logic              timeout_err,
   output logic              tx_dv,
   output logic [7:0]        tx_byte,
   input  logic              tx_active,
   input  logic              tx_done
);

   localparam int unsigned TO_W = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
   localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT_CLKS - 1);
   localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W + 1)'(DEPTH);

   typedef enum logic [1:0] {
      StIdle      = 2'd0,
      StWaitReady = 2'd1,
      StLaunch    = 2'd2,
      StWaitDone  = 2'd3
   } state_e;

   state_e            r_state;
   state_e            w_state_next;
   logic [7:0]        r_mem [DEPTH];
   logic [ADDR_W-1:0] r_wr_ptr;
   logic [ADDR_W-1:0] r_rd_ptr;
   logic [ADDR_W:0]   r_count;
   logic              r_overflow;
   logic              r_timeout_err;
   logic [7:0]        r_tx_byte;
   logic [TO_W-1:0]   r_to_cnt;

   logic              w_full;
   logic              w_empty;
   logic              w_push;
   logic              w_pop;
   logic              w_load_byte;
   logic              w_timeout_hit;

   // full is the pre-edge value, so a push coinciding with a pop at full is still dropped
   assign w_full  = (r_count == FULL_CNT);
   assign w_empty = (r_count == '0);
   assign w_push  = wr_en & ~w_full;
   assign w_pop   = (r_state == StLaunch);

   always_comb begin
      w_state_next  = r_state;
      w_load_byte   = 1'b0;
      w_timeout_hit = 1'b0;
      case (r_state)
         StIdle: begin
            if (!w_empty) w_state_next = StWaitReady;
         end
         StWaitReady: begin
            if (!tx_active) begin
               w_state_next = StLaunch;
               w_load_byte  = 1'b1;
            end
         end
         StLaunch: begin
            w_state_next = StWaitDone;
         end
         StWaitDone: begin
            // tx_done takes priority over a coincident timeout
            if (tx_done) begin
               w_state_next = StIdle;
            end else if (r_to_cnt == TO_LAST) begin
               w_timeout_hit = 1'b1;
               w_state_next  = StIdle;
            end
         end
         default: w_state_next = StIdle;
      endcase
   end

   always_ff @(posedge CLK_50 or posedge RST) begin
      if (RST) begin
         r_state       <= StIdle;
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_count       <= '0;
         r_overflow    <= 1'b0;
         r_timeout_err <= 1'b0;
         r_tx_byte     <= 8'h00;
         r_to_cnt      <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         if (wr_en && w_full) r_overflow <= 1'b1;
         if (w_timeout_hit)   r_timeout_err <= 1'b1;
         if (w_load_byte)     r_tx_byte <= r_mem[r_rd_ptr];
         if (r_state == StLaunch) begin
            r_to_cnt <= '0;
         end else if (r_state == StWaitDone) begin
            r_to_cnt <= r_to_cnt + 1'b1;
         end
      end
   end

   // Storage needs no reset: pointers and count define what is valid
   always_ff @(posedge CLK_50) begin
      if (w_push) r_mem[r_wr_ptr] <= wr_data;
   end

   assign full        = w_full;
   assign empty       = w_empty;
   assign count       = r_count;
   assign overflow    = r_overflow;
   assign timeout_err = r_timeout_err;
   assign tx_dv       = (r_state == StLaunch);
   assign tx_byte     = r_tx_byte;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Scoreboard bench for uart_tx_feeder: accepted pushes queue expected bytes,
// a negedge monitor pops and compares them on every tx_dv pulse.
`timescale 1ns / 1ps

module tb_uart_tx_feeder;

   localparam int unsigned DEPTH        = 16;
   localparam int unsigned ADDR_W       = 4;
   localparam int unsigned TIMEOUT_CLKS = 100;
   localparam int unsigned CLKS_PER_BIT = 8;
   localparam int unsigned FRAME        = 10 * CLKS_PER_BIT;

   logic              CLK_50 = 1'b0;
   logic              RST = 1'b1;
   logic              wr_en = 1'b0;
   logic [7:0]        wr_data = 8'h00;
   logic              full;
   logic              empty;
   logic [ADDR_W:0]   count;
   logic              overflow;
   logic              timeout_err;
   logic              tx_dv;
   logic [7:0]        tx_byte;
   logic              tx_active;
   logic              tx_done;

   logic              m_active;
   logic              m_done;
   int                m_cnt;
   logic              force_active = 1'b0;
   logic              done_disable = 1'b0;

   logic [7:0]        exp_q [$];
   int                n_checks = 0;
   int                n_pass = 0;
   int                n_pulses = 0;
   logic              prev_dv = 1'b0;

   uart_tx_feeder #(
      .DEPTH        (DEPTH),
      .ADDR_W       (ADDR_W),
      .TIMEOUT_CLKS (TIMEOUT_CLKS)
   ) dut (
      .CLK_50      (CLK_50),
      .RST         (RST),
      .wr_en       (wr_en),
      .wr_data     (wr_data),
      .full        (full),
      .empty       (empty),
      .count       (count),
      .overflow    (overflow),
      .timeout_err (timeout_err),
      .tx_dv       (tx_dv),
      .tx_byte     (tx_byte),
      .tx_active   (tx_active),
      .tx_done     (tx_done)
   );

   always #10 CLK_50 = ~CLK_50;

   assign tx_active = m_active | force_active;
   assign tx_done   = m_done;

   // uart_tx stand-in: busy for one frame after tx_dv, then a one-cycle done
   always @(posedge CLK_50 or posedge RST) begin
      if (RST) begin
         m_active <= 1'b0;
         m_done   <= 1'b0;
         m_cnt    <= 0;
      end else begin
         m_done <= 1'b0;
         if (m_active) begin
            if (m_cnt == 0) begin
               m_active <= 1'b0;
               m_done   <= 1'b1;
            end else begin
               m_cnt <= m_cnt - 1;
            end
         end else if (tx_dv && !done_disable) begin
            m_active <= 1'b1;
            m_cnt    <= FRAME - 1;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   always @(negedge CLK_50) begin
      if (RST) begin
         prev_dv = 1'b0;
      end else begin
         if (tx_dv) begin
            n_pulses++;
            check("dv_not_back_to_back", {31'd0, prev_dv}, 32'd0);
            check("dv_only_when_uart_idle", {31'd0, tx_active}, 32'd0);
            check("dv_has_pending_byte", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) check("tx_byte_order", {24'd0, tx_byte}, {24'd0, exp_q.pop_front()});
         end
         prev_dv = tx_dv;
      end
   end

   task automatic tick();
      @(posedge CLK_50);
      #1;
   endtask

   task automatic push(input logic [7:0] d, input bit accept);
      wr_en   = 1'b1;
      wr_data = d;
      if (accept) exp_q.push_back(d);
      tick();
      wr_en = 1'b0;
   endtask

   task automatic wait_drain(input int max);
      int n = 0;
      while ((exp_q.size() != 0 || !empty || tx_active) && n < max) begin
         tick();
         n++;
      end
      check("drain_in_time", {31'd0, n < max}, 32'd1);
      repeat (5) tick();
   endtask

   task automatic wait_dv(input int max, output int n);
      n = 0;
      do begin
         @(negedge CLK_50);
         n++;
      end while (!tx_dv && n < max);
      check("dv_seen_in_time", {31'd0, tx_dv}, 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int p0;
      int n;

      // Reset values while RST is held
      repeat (2) @(posedge CLK_50);
      @(negedge CLK_50);
      check("rst_count", {27'd0, count}, 32'd0);
      check("rst_empty", {31'd0, empty}, 32'd1);
      check("rst_full", {31'd0, full}, 32'd0);
      check("rst_tx_dv", {31'd0, tx_dv}, 32'd0);
      check("rst_tx_byte", {24'd0, tx_byte}, 32'd0);
      check("rst_overflow", {31'd0, overflow}, 32'd0);
      check("rst_timeout", {31'd0, timeout_err}, 32'd0);
      @(posedge CLK_50);
      #1 RST = 1'b0;
      repeat (2) tick();

      // Single byte: tx_dv high only in the cycle after the second edge past the push edge
      wr_en = 1'b1;
      wr_data = 8'h46;
      exp_q.push_back(8'h46);
      @(posedge CLK_50);
      #1 wr_en = 1'b0;
      @(negedge CLK_50);
      check("lat_dv_k", {31'd0, tx_dv}, 32'd0);
      @(negedge CLK_50);
      check("lat_dv_k1", {31'd0, tx_dv}, 32'd0);
      @(negedge CLK_50);
      check("lat_dv_k2", {31'd0, tx_dv}, 32'd1);
      check("lat_tx_byte", {24'd0, tx_byte}, 32'h46);
      @(negedge CLK_50);
      check("lat_dv_k3", {31'd0, tx_dv}, 32'd0);
      wait_drain(300);
      check("single_empty", {31'd0, empty}, 32'd1);
      check("single_tx_byte_hold", {24'd0, tx_byte}, 32'h46);

      // Ordering of three consecutive pushes
      p0 = n_pulses;
      push(8'h41, 1'b1);
      push(8'h42, 1'b1);
      push(8'h43, 1'b1);
      wait_drain(600);
      check("order_pulses", n_pulses - p0, 32'd3);

      // Fill to DEPTH with uart busy, then one dropped push (write pointer starts at 4, so it wraps)
      force_active = 1'b1;
      p0 = n_pulses;
      for (int i = 0; i < 16; i++) push(8'h60 + 8'(i), 1'b1);
      @(negedge CLK_50);
      check("fill_count", {27'd0, count}, 32'd16);
      check("fill_full", {31'd0, full}, 32'd1);
      check("fill_no_overflow", {31'd0, overflow}, 32'd0);
      push(8'h70, 1'b0);
      @(negedge CLK_50);
      check("ovf_flag", {31'd0, overflow}, 32'd1);
      check("ovf_count", {27'd0, count}, 32'd16);
      force_active = 1'b0;
      wait_drain(3000);
      check("fill_pulses", n_pulses - p0, 32'd16);
      check("ovf_sticky", {31'd0, overflow}, 32'd1);
      check("fill_drained", {31'd0, empty}, 32'd1);

      // Reset during LAUNCH
      push(8'h55, 1'b1);
      wait_dv(10, n);
      #2 RST = 1'b1;
      #1;
      check("rst_mid_dv", {31'd0, tx_dv}, 32'd0);
      check("rst_mid_count", {27'd0, count}, 32'd0);
      check("rst_mid_empty", {31'd0, empty}, 32'd1);
      check("rst_mid_tx_byte", {24'd0, tx_byte}, 32'd0);
      check("rst_mid_overflow", {31'd0, overflow}, 32'd0);
      @(posedge CLK_50);
      #1 RST = 1'b0;
      p0 = n_pulses;
      repeat (30) tick();
      check("rst_no_replay", n_pulses - p0, 32'd0);

      // Push coinciding with the pop edge at full: rejected
      force_active = 1'b1;
      for (int i = 0; i < 16; i++) push(8'h80 + 8'(i), 1'b1);
      check("sim16_count", {27'd0, count}, 32'd16);
      force_active = 1'b0;
      tick();
      check("sim16_launch", {31'd0, tx_dv}, 32'd1);
      push(8'hEE, 1'b0);
      @(negedge CLK_50);
      check("sim16_count_after", {27'd0, count}, 32'd15);
      check("sim16_overflow", {31'd0, overflow}, 32'd1);
      check("sim16_full", {31'd0, full}, 32'd0);
      wait_drain(3000);

      // Same case below full: both happen
      force_active = 1'b1;
      for (int i = 0; i < 5; i++) push(8'h90 + 8'(i), 1'b1);
      check("sim5_count", {27'd0, count}, 32'd5);
      force_active = 1'b0;
      tick();
      check("sim5_launch", {31'd0, tx_dv}, 32'd1);
      push(8'h95, 1'b1);
      @(negedge CLK_50);
      check("sim5_count_after", {27'd0, count}, 32'd5);
      wait_drain(1500);
      check("sim5_drained", exp_q.size(), 32'd0);

      // Timeout: uart never answers
      done_disable = 1'b1;
      push(8'hA1, 1'b1);
      push(8'hA2, 1'b1);
      wait_dv(10, n);
      @(posedge CLK_50);
      repeat (99) @(posedge CLK_50);
      @(negedge CLK_50);
      check("to_not_yet", {31'd0, timeout_err}, 32'd0);
      @(posedge CLK_50);
      @(negedge CLK_50);
      check("to_set", {31'd0, timeout_err}, 32'd1);
      wait_dv(10, n);
      check("to_relaunch_delay", n, 32'd2);
      repeat (120) tick();
      check("to_sticky", {31'd0, timeout_err}, 32'd1);
      check("to_all_sent", exp_q.size(), 32'd0);
      check("to_empty", {31'd0, empty}, 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
